mcycle_arith_unit: RTL

MCYCLE_ARITH_UNIT -- requirements
Module: mcycle_arith_unit

---
 rtl/mcycle_arith_pkg.sv | 34 +++
 rtl/mcycle_div_iter.sv | 79 +++++++
 rtl/mcycle_arith_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mcycle_arith_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mcycle_arith_pkg
//  Description : Shared definitions for the multi-cycle arithmetic unit:
//                opcode encodings, FSM state encoding, the add/sub execute
//                latency and a small constant-evaluation helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mcycle_arith_pkg;

    // Operation encodings carried on the opcode port
    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_SUB = 2'b01;
    localparam logic [1:0] c_OP_MUL = 2'b10;
    localparam logic [1:0] c_OP_DIV = 2'b11;

    // Execute latency of add and subtract, in cycles
    localparam int c_ADDSUB_LAT = 1;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EXEC = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    // Larger of two integers, used when sizing the latency counter
    function automatic int max_int(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mcycle_div_iter.sv
`default_nettype none
// ============================================================================
//  Module      : mcycle_div_iter
//  Description : Iterative unsigned restoring divider, one quotient bit per
//                cycle. A start pulse captures dividend and divisor; each
//                following cycle retires one registered step.
//                quotient/remainder present the result of the step being
//                computed in the current cycle, so the value seen in the
//                WIDTH-th cycle after start is the finished division.
//                Division by zero naturally yields quotient all-ones and
//                remainder equal to the dividend.
//  Ports       : clk, rst (async, active-high)
//                start            - load new operands
//                dividend/divisor - WIDTH-bit unsigned operands
//                quotient/remainder - WIDTH-bit step results
//  Revision    : 1.0 - initial release
// ============================================================================
module mcycle_div_iter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;   // unconsumed dividend bits in the top, quotient bits enter at the bottom
    logic [WIDTH-1:0]   r_dvs;
    logic [c_CNT_W-1:0] r_cnt;

    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH-1:0]   w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;

    // One restoring step. Because the running remainder is always below the
    // divisor, bit WIDTH of the trial difference is set exactly when the
    // subtraction underflows (and never set for a zero divisor).
    always_comb begin
        w_shift = {r_rem, r_quo[WIDTH-1]};
        w_trial = w_shift - {1'b0, r_dvs};
        if (w_trial[WIDTH]) begin
            w_rem_next = w_shift[WIDTH-1:0];
            w_quo_next = {r_quo[WIDTH-2:0], 1'b0};
        end else begin
            w_rem_next = w_trial[WIDTH-1:0];
            w_quo_next = {r_quo[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem <= '0;
            r_quo <= '0;
            r_dvs <= '0;
            r_cnt <= '0;
        end else if (start) begin
            r_rem <= '0;
            r_quo <= dividend;
            r_dvs <= divisor;
            r_cnt <= c_CNT_W'(WIDTH);
        end else if (r_cnt != '0) begin
            r_rem <= w_rem_next;
            r_quo <= w_quo_next;
            r_cnt <= r_cnt - c_CNT_W'(1);
        end
    end

    assign quotient  = w_quo_next;
    assign remainder = w_rem_next;

endmodule
`default_nettype wire

// File: rtl/mcycle_arith_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mcycle_arith_unit
//  Description : Multi-cycle unsigned add/sub/mul/div unit with a
//                IDLE -> LOAD -> EXEC -> OUT controller. Operands are
//                captured during LOAD; EXEC lasts 1 cycle for add/sub,
//                MUL_LAT cycles for mul and WIDTH cycles for div; result and
//                err are registered on entry to OUT and held afterwards.
//  Config      : MCYCLE_ARITH_DIV_EN - when defined the restoring divider is
//                built; otherwise opcode 11 completes in one EXEC cycle with
//                result 0 and err 1.
//  Ports       : clk, rst (async, active-high)
//                go      - start request, honoured only in IDLE
//                opcode  - 00 add, 01 sub, 10 mul, 11 div
//                a, b    - WIDTH-bit unsigned operands
//                result  - 2*WIDTH-bit registered result
//                done    - high for the single OUT cycle
//                busy    - high whenever not IDLE
//                err     - divide error of the last operation
//  Revision    : 1.0 - initial release
// ============================================================================
module mcycle_arith_unit
    import mcycle_arith_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MUL_LAT = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    input  logic [1:0]         opcode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] result,
    output logic               done,
    output logic               busy,
    output logic               err
);

    // Counter holds (EXEC length - 1), so it only needs to reach max-1
    localparam int c_MAX_LAT = max_int(MUL_LAT, WIDTH);
    localparam int c_CNT_W   = (c_MAX_LAT > 1) ? $clog2(c_MAX_LAT) : 1;

    state_t             r_state;
    state_t             w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_lat_m1;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_result;
    logic [2*WIDTH-1:0] w_result_next;
    logic               r_err;
    logic               w_err_next;
    logic               w_exec_last;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_prod;

    assign w_exec_last = (r_state == ST_EXEC) && (r_cnt == '0);

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (go) w_state_next = ST_LOAD;
            ST_LOAD: w_state_next = ST_EXEC;
            ST_EXEC: if (r_cnt == '0) w_state_next = ST_OUT;
            ST_OUT:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // EXEC length minus one for the operation being loaded. The opcode port
    // is used directly because it is captured on the same edge.
    always_comb begin
        w_lat_m1 = c_CNT_W'(c_ADDSUB_LAT - 1);
        case (opcode)
            c_OP_MUL: w_lat_m1 = c_CNT_W'(MUL_LAT - 1);
`ifdef MCYCLE_ARITH_DIV_EN
            c_OP_DIV: w_lat_m1 = c_CNT_W'(WIDTH - 1);
`endif
            default:  w_lat_m1 = c_CNT_W'(c_ADDSUB_LAT - 1);
        endcase
    end

    // ------------------------------------------------------------------
    // Operand capture and latency counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
        end else if (r_state == ST_LOAD) begin
            r_op  <= opcode;
            r_a   <= a;
            r_b   <= b;
            r_cnt <= w_lat_m1;
        end else if ((r_state == ST_EXEC) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - c_CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Divider
    // ------------------------------------------------------------------
`ifdef MCYCLE_ARITH_DIV_EN
    logic             w_div_start;
    logic [WIDTH-1:0] w_div_quo;
    logic [WIDTH-1:0] w_div_rem;

    // Started from LOAD with the port values so that its WIDTH steps line up
    // exactly with the WIDTH EXEC cycles.
    assign w_div_start = (r_state == ST_LOAD);

    mcycle_div_iter #(
        .WIDTH     (WIDTH)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (w_div_start),
        .dividend  (a),
        .divisor   (b),
        .quotient  (w_div_quo),
        .remainder (w_div_rem)
    );
`endif

    // ------------------------------------------------------------------
    // Result selection
    // ------------------------------------------------------------------
    always_comb begin
        w_sum         = {1'b0, r_a} + {1'b0, r_b};
        // Bit WIDTH of the widened difference is the borrow (a < b)
        w_diff        = {1'b0, r_a} - {1'b0, r_b};
        w_prod        = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
        w_result_next = '0;
        w_err_next    = 1'b0;
        case (r_op)
            c_OP_ADD: w_result_next = {{(WIDTH-1){1'b0}}, w_sum};
            c_OP_SUB: w_result_next = {{(WIDTH-1){1'b0}}, w_diff};
            c_OP_MUL: w_result_next = w_prod;
            default: begin
`ifdef MCYCLE_ARITH_DIV_EN
                w_result_next = {w_div_rem, w_div_quo};
                w_err_next    = (r_b == '0);
`else
                w_result_next = '0;
                w_err_next    = 1'b1;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_err    <= 1'b0;
        end else if (w_exec_last) begin
            r_result <= w_result_next;
            r_err    <= w_err_next;
        end
    end

    assign result = r_result;
    assign err    = r_err;
    assign done   = (r_state == ST_OUT);
    assign busy   = (r_state != ST_IDLE);

endmodule
`default_nettype wire
